// File: rtl/cordic_vmod.sv
`default_nettype none
// cordic_vmod -- iterative vectoring-mode CORDIC: atan2(y,x) as a 32-bit turn value plus gain-compensated magnitude.
// Revision 1.0
module cordic_vmod #(
   parameter int unsigned ITER   = 16,
   parameter logic [15:0] K_COMP = 16'h9B75
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [17:0] x_in,
   input  logic [17:0] y_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] phase_out,
   output logic [17:0] mag_out
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ITER   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   localparam logic [31:0] C_THETA [32] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
      32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
      32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
      32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
      32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
   };

   state_t             state_q, state_d;
   logic signed [31:0] x_q, x_d, y_q, y_d;
   logic [31:0]        z_q, z_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [31:0]        phase_q, phase_d;
   logic [17:0]        mag_q, mag_d;

   logic signed [31:0] w_x_ld, w_y_ld, w_x_sh, w_y_sh;
   logic [35:0]        w_prod;
   logic [19:0]        w_mag20;

   // Two guard bits above the 18-bit input keep -(-2^17) and the CORDIC gain in range.
   assign w_x_ld  = {{2{x_in[17]}}, x_in, 12'b0};
   assign w_y_ld  = {{2{y_in[17]}}, y_in, 12'b0};
   assign w_x_sh  = x_q >>> cnt_q;
   assign w_y_sh  = y_q >>> cnt_q;
   assign w_prod  = {16'b0, x_q[31:12]} * {20'b0, K_COMP};
   assign w_mag20 = 20'(w_prod >> 16);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      phase_d = phase_q;
      mag_d   = mag_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = 5'd0;
               busy_d  = 1'b1;
               state_d = S_ITER;
               if (!x_in[17]) begin
                  x_d = w_x_ld;
                  y_d = w_y_ld;
                  z_d = 32'h0000_0000;
               end else if (!y_in[17]) begin
                  x_d = w_y_ld;
                  y_d = -w_x_ld;
                  z_d = 32'h4000_0000;
               end else begin
                  x_d = -w_y_ld;
                  y_d = w_x_ld;
                  z_d = 32'hC000_0000;
               end
            end
         end
         S_ITER: begin
            if (!y_q[31]) begin
               x_d = x_q + w_y_sh;
               y_d = y_q - w_x_sh;
               z_d = z_q + C_THETA[cnt_q];
            end else begin
               x_d = x_q - w_y_sh;
               y_d = y_q + w_x_sh;
               z_d = z_q - C_THETA[cnt_q];
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(ITER - 1)) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            phase_d = z_q;
            mag_d   = (|w_mag20[19:18]) ? 18'h3FFFF : w_mag20[17:0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         phase_q <= '0;
         mag_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         phase_q <= phase_d;
         mag_q   <= mag_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign phase_out = phase_q;
   assign mag_out   = mag_q;

endmodule
`default_nettype wire
